// File: rtl/vga_timing_gen_if.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_gen_if
// Description : Bundle of run controls, pixel input and timing outputs for
//               vga_timing_gen. The timing generator is the master. The
//               consumer (display pipeline or bench) is the slave.
//   en          run enable (slave -> master)
//   tp_en       test-pattern select (slave -> master)
//   rgb_in      pixel colour from the frame source (slave -> master)
//   hsync/vsync sync outputs, polarity set by the generator parameters
//   video_on    high while (pix_x, pix_y) is in the active area
//   pix_tick    one-clk pixel strobe
//   pix_x/pix_y 11-bit current pixel coordinates
//   line_start  strobe on the edge that moves pix_x to 0
//   frame_start strobe on the edge that moves (pix_x, pix_y) to (0,0)
//   rgb         colour output, blanked outside the active area
// Revision    : 1.0 - initial release
// ============================================================================
interface vga_timing_gen_if #(
  parameter int RGB_W = 3
);
  logic             en;
  logic             tp_en;
  logic [RGB_W-1:0] rgb_in;
  logic             hsync;
  logic             vsync;
  logic             video_on;
  logic             pix_tick;
  logic [10:0]      pix_x;
  logic [10:0]      pix_y;
  logic             line_start;
  logic             frame_start;
  logic [RGB_W-1:0] rgb;

  modport master (
    input  en, tp_en, rgb_in,
    output hsync, vsync, video_on, pix_tick, pix_x, pix_y,
           line_start, frame_start, rgb
  );

  modport slave (
    output en, tp_en, rgb_in,
    input  hsync, vsync, video_on, pix_tick, pix_x, pix_y,
           line_start, frame_start, rgb
  );
endinterface
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_gen
// Description : Parametrised VGA timing generator. A clock divider produces
//               the pixel strobe, 11-bit horizontal/vertical counters walk
//               the frame, and registered sync / active-video flags are
//               loaded from the next counter values so they stay aligned
//               with pix_x / pix_y. Colour output is blanked outside the
//               active area.
//               Optional feature macro: VGA_TESTPATTERN_EN builds an 8-bar
//               colour test pattern selected by tp_en.
// Ports       :
//   clk_i   system clock
//   rst_ni  asynchronous active-low reset
//   bus     vga_timing_gen_if.master (en, tp_en, rgb_in in; timing and
//           colour out)
// Parameters  : H_ACTIVE (multiple of 8), H_FP, H_SYNC, H_BP, V_ACTIVE,
//               V_FP, V_SYNC, V_BP, CLK_DIV (>=1), HSYNC_POL, VSYNC_POL,
//               RGB_W. Horizontal and vertical totals must be <= 2048.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_timing_gen #(
  parameter int H_ACTIVE  = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter int CLK_DIV   = 2,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0,
  parameter int RGB_W     = 3
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  vga_timing_gen_if.master bus
);

  // --------------------------------------------------------------------------
  // Derived geometry
  // --------------------------------------------------------------------------
  localparam int          H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int          V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_ACT    = 11'(H_ACTIVE);
  localparam logic [10:0] V_ACT    = 11'(V_ACTIVE);
  localparam logic [10:0] HS_FIRST = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_LAST  = 11'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [10:0] VS_FIRST = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_LAST  = 11'(V_ACTIVE + V_FP + V_SYNC - 1);

  // A divide-by-one still keeps a 1-bit divider that never leaves 0, so the
  // pixel strobe degenerates to the enable itself.
  localparam int             DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [DIV_W-1:0] div_q, div_d;
  logic [10:0]      x_q, x_d;
  logic [10:0]      y_q, y_d;
  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;
  logic             vo_q, vo_d;

  logic             w_tick;
  logic             w_h_wrap;
  logic             w_v_wrap;

  assign w_tick   = bus.en & (div_q == DIV_LAST);
  assign w_h_wrap = w_tick & (x_q == H_LAST);
  assign w_v_wrap = w_h_wrap & (y_q == V_LAST);

  // --------------------------------------------------------------------------
  // Divider next state: free-runs 0..CLK_DIV-1 while enabled, holds otherwise
  // --------------------------------------------------------------------------
  always_comb begin
    div_d = div_q;
    if (bus.en) begin
      if (div_q == DIV_LAST) begin
        div_d = '0;
      end else begin
        div_d = div_q + 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Counter next state and the flags derived from it. Decoding the flags from
  // the next counter values lets them be registered on the same edge as the
  // counters, so they carry no latency relative to pix_x / pix_y.
  // --------------------------------------------------------------------------
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (w_tick) begin
      if (x_q == H_LAST) begin
        x_d = '0;
        if (y_q == V_LAST) begin
          y_d = '0;
        end else begin
          y_d = y_q + 11'd1;
        end
      end else begin
        x_d = x_q + 11'd1;
      end
    end

    hsync_d = ((x_d >= HS_FIRST) && (x_d <= HS_LAST)) ? HSYNC_POL : ~HSYNC_POL;
    vsync_d = ((y_d >= VS_FIRST) && (y_d <= VS_LAST)) ? VSYNC_POL : ~VSYNC_POL;
    vo_d    = (x_d < H_ACT) && (y_d < V_ACT);
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      div_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      hsync_q <= ~HSYNC_POL;
      vsync_q <= ~VSYNC_POL;
      vo_q    <= 1'b1;
    end else begin
      div_q <= div_d;
      if (w_tick) begin
        x_q     <= x_d;
        y_q     <= y_d;
        hsync_q <= hsync_d;
        vsync_q <= vsync_d;
        vo_q    <= vo_d;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Colour path
  // --------------------------------------------------------------------------
`ifdef VGA_TESTPATTERN_EN
  // Eight vertical bars across the active width. The sub-counter counts
  // pixels within a bar; both counters track the next x value so the bar
  // index is aligned with pix_x, clear at x=0 and freeze in blanking.
  localparam int               BAR_W    = H_ACTIVE / 8;
  localparam int               SUB_W    = (BAR_W > 1) ? $clog2(BAR_W) : 1;
  localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(BAR_W - 1);

  logic [2:0]       bar_q, bar_d;
  logic [SUB_W-1:0] sub_q, sub_d;
  logic [RGB_W-1:0] w_bar_rgb;

  always_comb begin
    bar_d = bar_q;
    sub_d = sub_q;
    if (x_d == 11'd0) begin
      bar_d = '0;
      sub_d = '0;
    end else if (x_d < H_ACT) begin
      if (sub_q == SUB_LAST) begin
        sub_d = '0;
        bar_d = bar_q + 3'd1;
      end else begin
        sub_d = sub_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      bar_q <= '0;
      sub_q <= '0;
    end else if (w_tick) begin
      bar_q <= bar_d;
      sub_q <= sub_d;
    end
  end

  // Bar index is zero-extended or truncated to the colour width.
  assign w_bar_rgb = RGB_W'(bar_q);
  assign bus.rgb   = !vo_q     ? '0        :
                     bus.tp_en ? w_bar_rgb : bus.rgb_in;
`else
  logic w_unused_tp_en;
  assign w_unused_tp_en = bus.tp_en;
  assign bus.rgb        = vo_q ? bus.rgb_in : '0;
`endif

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign bus.pix_tick    = w_tick;
  assign bus.line_start  = w_h_wrap;
  assign bus.frame_start = w_v_wrap;
  assign bus.pix_x       = x_q;
  assign bus.pix_y       = y_q;
  assign bus.hsync       = hsync_q;
  assign bus.vsync       = vsync_q;
  assign bus.video_on    = vo_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_timing_gen
// Description : Self-checking bench for vga_timing_gen. One instance uses
//               the default 640x480 geometry with CLK_DIV=2. A second uses a
//               tiny 14x8 geometry with CLK_DIV=1 and active-high hsync.
//               The test-pattern expectations follow VGA_TESTPATTERN_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

`ifdef VGA_TESTPATTERN_EN
  localparam bit TP_BUILT = 1'b1;
`else
  localparam bit TP_BUILT = 1'b0;
`endif

  vga_timing_gen_if #(.RGB_W(3)) bus_d ();
  vga_timing_gen_if #(.RGB_W(3)) bus_s ();

  vga_timing_gen #(.CLK_DIV(2)) u_dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus_d)
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .CLK_DIV(1), .HSYNC_POL(1'b1), .VSYNC_POL(1'b0), .RGB_W(3)
  ) u_small (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus_s)
  );

  typedef struct {
    int         x;
    logic       tp;
    logic [2:0] rgb_in;
    logic       hs;
    logic       vo;
    logic [2:0] rgb;
  } vec_t;

  vec_t vecs [13];

  // Expected colour for an active pixel with tp_en=1 and rgb_in=3'b110.
  function automatic logic [2:0] tpx(input logic [2:0] bar);
    return TP_BUILT ? bar : 3'b110;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_x(input int target, input string name);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if (int'(bus_d.pix_x) == target) begin
        hit = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!hit) begin
      tests++;
      fails++;
      $display("FAIL %s: timed out waiting for pix_x=%0d", name, target);
    end
  endtask

  task automatic wait_ls(input string name);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if (bus_d.line_start) begin
        hit = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!hit) begin
      tests++;
      fails++;
      $display("FAIL %s: timed out waiting for line_start", name);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    int cnt, hs_low, vo_hi, first_ls, bad, y0, mx, my, fs_cnt, first_fs, last_fs;
    logic hs0, vs0;
    bit hit;
    logic [26:0] act_v, exp_v;

    //            x    tp    rgb_in  hs    vo    rgb
    vecs[0]  = '{5,   1'b0, 3'b101, 1'b1, 1'b1, 3'b101};
    vecs[1]  = '{79,  1'b1, 3'b110, 1'b1, 1'b1, tpx(3'd0)};
    vecs[2]  = '{80,  1'b1, 3'b110, 1'b1, 1'b1, tpx(3'd1)};
    vecs[3]  = '{300, 1'b1, 3'b110, 1'b1, 1'b1, tpx(3'd3)};
    vecs[4]  = '{559, 1'b1, 3'b110, 1'b1, 1'b1, tpx(3'd6)};
    vecs[5]  = '{560, 1'b1, 3'b110, 1'b1, 1'b1, tpx(3'd7)};
    vecs[6]  = '{639, 1'b1, 3'b110, 1'b1, 1'b1, tpx(3'd7)};
    vecs[7]  = '{640, 1'b1, 3'b110, 1'b1, 1'b0, 3'b000};
    vecs[8]  = '{655, 1'b0, 3'b101, 1'b1, 1'b0, 3'b000};
    vecs[9]  = '{656, 1'b0, 3'b101, 1'b0, 1'b0, 3'b000};
    vecs[10] = '{751, 1'b0, 3'b101, 1'b0, 1'b0, 3'b000};
    vecs[11] = '{752, 1'b0, 3'b101, 1'b1, 1'b0, 3'b000};
    vecs[12] = '{799, 1'b0, 3'b101, 1'b1, 1'b0, 3'b000};

    rst_n        = 1'b0;
    bus_d.en     = 1'b1;
    bus_d.tp_en  = 1'b0;
    bus_d.rgb_in = 3'b000;
    bus_s.en     = 1'b1;
    bus_s.tp_en  = 1'b0;
    bus_s.rgb_in = 3'b000;

    // ---------------- reset state ----------------
    repeat (3) @(negedge clk);
    check("rst_hsync",   int'(bus_d.hsync),    1);
    check("rst_vsync",   int'(bus_d.vsync),    1);
    check("rst_x",       int'(bus_d.pix_x),    0);
    check("rst_y",       int'(bus_d.pix_y),    0);
    check("rst_vo",      int'(bus_d.video_on), 1);
    check("rst_small_hsync", int'(bus_s.hsync), 0);
    check("rst_small_vsync", int'(bus_s.vsync), 1);
    rst_n = 1'b1;

    // ---------------- table: first line, y=0 ----------------
    for (int i = 0; i < 13; i++) begin
      wait_x(vecs[i].x, "vec_wait");
      bus_d.tp_en  = vecs[i].tp;
      bus_d.rgb_in = vecs[i].rgb_in;
      #1;
      check($sformatf("vec%0d_hsync", i), int'(bus_d.hsync),    int'(vecs[i].hs));
      check($sformatf("vec%0d_vo", i),    int'(bus_d.video_on), int'(vecs[i].vo));
      check($sformatf("vec%0d_rgb", i),   int'(bus_d.rgb),      int'(vecs[i].rgb));
      check($sformatf("vec%0d_vsync", i), int'(bus_d.vsync),    1);
    end
    bus_d.tp_en  = 1'b0;
    bus_d.rgb_in = 3'b101;

    // ---------------- one full line window ----------------
    wait_ls("line_win_start");
    cnt = 0; hs_low = 0; vo_hi = 0; first_ls = 0;
    for (int i = 1; i <= 1600; i++) begin
      @(negedge clk);
      if (bus_d.pix_tick) cnt++;
      if (!bus_d.hsync) hs_low++;
      if (bus_d.video_on) vo_hi++;
      if (bus_d.line_start && first_ls == 0) first_ls = i;
    end
    check("line_period_clks", first_ls, 1600);
    check("line_ticks",       cnt,      800);
    check("hsync_low_clks",   hs_low,   192);
    check("video_on_clks",    vo_hi,    1280);
    check("line_end_y",       int'(bus_d.pix_y), 1);

    // ---------------- enable freeze at x=100 ----------------
    wait_x(100, "en_wait");
    y0  = int'(bus_d.pix_y);
    hs0 = bus_d.hsync;
    vs0 = bus_d.vsync;
    bus_d.en = 1'b0;
    bad = 0;
    repeat (50) begin
      @(negedge clk);
      if (bus_d.pix_x != 11'd100 || int'(bus_d.pix_y) != y0 || bus_d.hsync != hs0 ||
          bus_d.vsync != vs0 || bus_d.pix_tick || bus_d.line_start)
        bad++;
    end
    check("en_frozen_bad_cycles", bad, 0);
    check("en_hold_x", int'(bus_d.pix_x), 100);
    check("en_hold_y", int'(bus_d.pix_y), 2);
    bus_d.en = 1'b1;
    #1;
    cnt = 0; hit = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if (bus_d.pix_tick) cnt++;
      if (bus_d.line_start) begin
        hit = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("en_line_end_seen",   int'(hit), 1);
    check("en_remaining_ticks", cnt, 700);

    // ---------------- asynchronous reset mid-line ----------------
    wait_x(300, "rst_wait");
    check("pre_rst_y", int'(bus_d.pix_y), 3);
    rst_n = 1'b0;
    #1;
    check("mid_rst_x",     int'(bus_d.pix_x),    0);
    check("mid_rst_y",     int'(bus_d.pix_y),    0);
    check("mid_rst_hsync", int'(bus_d.hsync),    1);
    check("mid_rst_vsync", int'(bus_d.vsync),    1);
    check("mid_rst_vo",    int'(bus_d.video_on), 1);
    repeat (2) @(negedge clk);

    // ---------------- small geometry, two frames ----------------
    rst_n = 1'b1;
    mx = 0; my = 0; fs_cnt = 0; first_fs = -1; last_fs = -1;
    for (int k = 0; k < 224; k++) begin
      #1;
      act_v = {bus_s.pix_x, bus_s.pix_y, bus_s.hsync, bus_s.vsync,
               bus_s.video_on, bus_s.line_start, bus_s.frame_start};
      exp_v = {11'(mx), 11'(my),
               (mx >= 10 && mx <= 12),
               !(my >= 5 && my <= 6),
               (mx < 8 && my < 4),
               (mx == 13),
               (mx == 13 && my == 7)};
      check($sformatf("small_k%0d_x%0d_y%0d", k, mx, my), int'(act_v), int'(exp_v));
      if (bus_s.frame_start) begin
        fs_cnt++;
        if (first_fs < 0) first_fs = k;
        last_fs = k;
      end
      if (mx == 13) begin
        mx = 0;
        my = (my == 7) ? 0 : my + 1;
      end else begin
        mx = mx + 1;
      end
      @(negedge clk);
    end
    check("small_frame_pulses", fs_cnt, 2);
    check("small_frame_period", last_fs - first_fs, 112);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
